instr_sequencer: RTL and testbench

//  Multicycle control FSM for the 8-bit accumulator-style core.
//  - Fetches each instruction into an instruction register (IR) that feeds the combinational decoder.
//  - Consumes the decoder's control outputs and sequences EXEC, data memory and register writeback.
//  - Updates the PC, including branches and jumps resolved through the label LUT.
//  - Arbitrates the single data-memory port with a req/ready handshake and a timeout.

---
 rtl/instr_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multicycle control sequencer for the 8-bit accumulator core.
// Fetches into the IR, walks DECODE/EXEC/MEM/WB from the decoder's controls,
// updates the PC (sequential, branch, jump via label LUT) and runs the single
// data-memory port with a req/ready handshake and a wait timeout.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   start                        begin run at PC 0 (honoured in IDLE/HALT only)
//   instr_i                      instruction memory data at pc_o
//   dec_*                        decoder controls derived from instr_o
//   target_pc_i                  label LUT data for lut_idx_o
//   alu_zero_i                   ALU zero flag (used in EXEC)
//   mem_ready_i                  data memory completes current request
//   pc_o, instr_o, lut_idx_o     PC, IR, LUT index
//   mem_req_o, mem_we_o, reg_we_o strobes
//   busy_o, done_o, err_o        run status
//   cycle_cnt_o                  saturating busy-cycle counter
module instr_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned CYC_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       instr_i,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic [3:0]       dec_target,
  input  logic [PC_W-1:0]  target_pc_i,
  input  logic             alu_zero_i,
  input  logic             mem_ready_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [7:0]       instr_o,
  output logic [3:0]       lut_idx_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             reg_we_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CYC_W-1:0] cycle_cnt_o
);

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned WAIT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d, pc_inc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic               reg_we_q, reg_we_d;
  logic               busy_q, busy_d;

  assign pc_inc   = pc_q + PC_W'(1);
  assign wait_inc = wait_q + WAIT_W'(1);

  // Next-state, datapath updates and next strobe values
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    err_d   = err_q;

    if (busy_q && (cnt_q != {CYC_W{1'b1}})) cnt_d = cnt_q + CYC_W'(1);

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = instr_i;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        if (dec_mem_read || dec_mem_write) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else if (dec_reg_write) begin
          state_d = S_WB;
        end else begin
          pc_d    = (dec_jump || (dec_branch && alu_zero_i)) ? target_pc_i : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ready_i) begin
          // read wins when the decoder asserts both
          if (dec_mem_read) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Moore strobes, registered alongside the state they belong to
    mem_req_d = (state_d == S_MEM);
    mem_we_d  = (state_d == S_MEM) && dec_mem_write && !dec_mem_read;
    reg_we_d  = (state_d == S_WB);
    busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
                (state_d == S_MEM)   || (state_d == S_WB);
    done_d    = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      done_q    <= done_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      reg_we_q  <= reg_we_d;
      busy_q    <= busy_d;
    end
  end

  assign pc_o        = pc_q;
  assign instr_o     = ir_q;
  assign lut_idx_o   = dec_target;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign reg_we_o    = reg_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: small opcode decoder, instruction
// memory and label LUT around the DUT; table of single-instruction programs
// checked through a scoreboard queue, plus hand-written timing/reset sequences.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] instr_i;
  logic       dec_mem_read, dec_mem_write, dec_reg_write;
  logic       dec_branch, dec_jump, dec_halt;
  logic [3:0] dec_target;
  logic [7:0] target_pc_i;
  logic       alu_zero_i;
  logic       mem_ready_i;
  logic [7:0] pc_o, instr_o;
  logic [3:0] lut_idx_o;
  logic       mem_req_o, mem_we_o, reg_we_o, busy_o, done_o, err_o;
  logic [15:0] cycle_cnt_o;

  logic [7:0] imem [256];
  logic [7:0] lut  [16];

  // opcodes (high nibble): 1 add, 2 beq0, 3 jmp, 4 ld, 5 st, 6 halt, 7 ld+st
  localparam logic [7:0] HALT = 8'h60;

  int checks = 0;
  int failures = 0;
  int n_rw, n_mr, n_mw;
  int cur_delay = 255;
  logic cur_noisy = 1'b0;
  int mem_cycle = 0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_i(instr_i),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .dec_branch(dec_branch), .dec_jump(dec_jump),
    .dec_halt(dec_halt), .dec_target(dec_target), .target_pc_i(target_pc_i),
    .alu_zero_i(alu_zero_i), .mem_ready_i(mem_ready_i), .pc_o(pc_o),
    .instr_o(instr_o), .lut_idx_o(lut_idx_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .reg_we_o(reg_we_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cycle_cnt_o(cycle_cnt_o)
  );

  assign instr_i     = imem[pc_o];
  assign target_pc_i = lut[lut_idx_o];

  always_comb begin
    logic [3:0] op;
    op            = instr_o[7:4];
    dec_mem_read  = (op == 4'd4) || (op == 4'd7);
    dec_mem_write = (op == 4'd5) || (op == 4'd7);
    dec_reg_write = (op == 4'd1) || (op == 4'd4) || (op == 4'd7);
    dec_branch    = (op == 4'd2);
    dec_jump      = (op == 4'd3);
    dec_halt      = (op == 4'd6);
    dec_target    = instr_o[3:0];
  end

  // Strobe monitor and data-memory responder
  always @(negedge clk) begin
    if (reg_we_o) n_rw++;
    if (mem_req_o) begin
      n_mr++;
      if (mem_we_o) n_mw++;
      mem_ready_i = (mem_cycle == cur_delay);
      mem_cycle++;
    end else begin
      mem_ready_i = cur_noisy;
      mem_cycle = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = HALT;
    for (int i = 0; i < 16; i++) lut[i] = 8'h00;
  endtask

  // start pulse sampled at the next posedge; returns 1 once done_o is seen
  task automatic run_to_done(output bit got);
    got = 0;
    @(negedge clk);
    n_rw = 0; n_mr = 0; n_mw = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done_o) begin got = 1; break; end
    end
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       zero;
    logic [7:0] tgt;
    int         delay;
    logic       noisy;
    logic [7:0] e_pc;
    int         e_cnt, e_rw, e_mr, e_mw;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];

  initial begin
    bit got;
    logic [5:0] rw_seq;
    vec_t v, e;

    rst_n = 1'b0; start = 1'b0; alu_zero_i = 1'b0; mem_ready_i = 1'b0;
    clear_mem();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_cnt", cycle_cnt_o, 0);
    chk("rst_strobes", {mem_req_o, mem_we_o, reg_we_o, busy_o, done_o, err_o}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start", {busy_o, done_o, pc_o}, 0);

    // Register op latency: WB in cycle 4, pc=1 in cycle 5
    imem[0] = 8'h10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rw_seq = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rw_seq[k-1] = reg_we_o;
      if (k == 5) begin
        chk("add_pc_c5", pc_o, 1);
        chk("add_cnt_c5", cycle_cnt_o, 4);
      end
    end
    chk("add_regwe_seq", rw_seq, 6'b001000);

    // Table: {instr, zero, tgt, delay, noisy, pc, cnt, reg_we, mem_req, mem_we, err}
    vecs.push_back('{8'h11, 1'b0, 8'h00,   0, 1'b1, 8'h01,  6, 1,  0, 0, 1'b0});
    vecs.push_back('{8'h21, 1'b1, 8'h20,   0, 1'b0, 8'h20,  5, 0,  0, 0, 1'b0});
    vecs.push_back('{8'h21, 1'b0, 8'h20,   0, 1'b0, 8'h01,  5, 0,  0, 0, 1'b0});
    vecs.push_back('{8'h32, 1'b0, 8'h40,   0, 1'b0, 8'h40,  5, 0,  0, 0, 1'b0});
    vecs.push_back('{8'h40, 1'b0, 8'h00,   3, 1'b0, 8'h01, 10, 1,  4, 0, 1'b0});
    vecs.push_back('{8'h40, 1'b0, 8'h00,   0, 1'b0, 8'h01,  7, 1,  1, 0, 1'b0});
    vecs.push_back('{8'h50, 1'b0, 8'h00,   2, 1'b0, 8'h01,  8, 0,  3, 3, 1'b0});
    vecs.push_back('{8'h70, 1'b0, 8'h00,   1, 1'b0, 8'h01,  8, 1,  2, 0, 1'b0});
    vecs.push_back('{8'h40, 1'b0, 8'h00, 255, 1'b0, 8'h00, 18, 0, 15, 0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      clear_mem();
      imem[0] = v.instr;
      lut[v.instr[3:0]] = v.tgt;
      alu_zero_i = v.zero;
      cur_delay = v.delay;
      cur_noisy = v.noisy;
      sbq.push_back(v);
      run_to_done(got);
      e = sbq.pop_front();
      chk($sformatf("v%0d_done", i), got, 1);
      chk($sformatf("v%0d_pc", i), pc_o, e.e_pc);
      chk($sformatf("v%0d_cnt", i), cycle_cnt_o, e.e_cnt);
      chk($sformatf("v%0d_regwe", i), n_rw, e.e_rw);
      chk($sformatf("v%0d_memreq", i), n_mr, e.e_mr);
      chk($sformatf("v%0d_memwe", i), n_mw, e.e_mw);
      chk($sformatf("v%0d_err", i), err_o, e.e_err);
      chk($sformatf("v%0d_idle_strobes", i), {mem_req_o, reg_we_o, busy_o}, 0);
    end
    cur_noisy = 1'b0;

    // Restart after error, halt at pc 5, start while busy ignored
    clear_mem();
    for (int a = 0; a < 5; a++) imem[a] = 8'h10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_flags", {done_o, err_o, busy_o}, 3'b001);
    chk("restart_pc", pc_o, 0);
    repeat (7) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (done_o) begin got = 1; break; end
    end
    chk("halt_done", got, 1);
    chk("halt_pc", pc_o, 5);
    chk("halt_cnt", cycle_cnt_o, 22);
    repeat (4) @(negedge clk);
    chk("halt_cnt_frozen", cycle_cnt_o, 22);
    chk("halt_pc_hold", pc_o, 5);

    // PC wrap: jump to 0xFF, add there, wraps to 0 which then halts
    clear_mem();
    lut[1] = 8'hFF;
    imem[0] = 8'h31;
    imem[8'hFF] = 8'h10;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (pc_o == 8'hFF) begin got = 1; break; end
    end
    chk("wrap_reach_ff", got, 1);
    imem[0] = HALT;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (done_o) begin got = 1; break; end
    end
    chk("wrap_done", got, 1);
    chk("wrap_pc", pc_o, 0);
    chk("wrap_cnt", cycle_cnt_o, 9);

    // Async reset during an outstanding memory request
    clear_mem();
    lut[1] = 8'h10;
    imem[0] = 8'h31;
    imem[8'h10] = 8'h40;
    cur_delay = 255;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req_o) begin got = 1; break; end
    end
    chk("rstmem_req_seen", got, 1);
    chk("rstmem_pc_before", pc_o, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("rstmem_now", {mem_req_o, busy_o, reg_we_o}, 0);
    chk("rstmem_pc_now", pc_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmem_stay_idle", {mem_req_o, busy_o, done_o, pc_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
